// File: rtl/serial_subtractor_nand.sv
// serial_subtractor_nand: bit-serial a-b, LSB first, full-subtractor cell from 2-input NANDs only.
// Define SERIAL_SUB_OVF_EN to build the signed overflow flag; otherwise ovf is tied low.
module serial_subtractor_nand #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] opa, opb, res, res_nxt;
    logic [CW-1:0] cnt;
    logic brw, last, accept;
    logic n1, n2, n3, xo, m1, m2, m3, d, bo;
    // n3 and m3 are the inverted half-subtractor borrows, so one NAND merges them
    nand g1 (n1, opa[0], opb[0]);
    nand g2 (n2, opa[0], n1);
    nand g3 (n3, opb[0], n1);
    nand g4 (xo, n2, n3);
    nand g5 (m1, xo, brw);
    nand g6 (m2, xo, m1);
    nand g7 (m3, brw, m1);
    nand g8 (d, m2, m3);
    nand g9 (bo, n3, m3);
    assign res_nxt = {d, res[WIDTH-1:1]};
    assign last    = cnt == CW'(WIDTH - 1);
    assign accept  = state == IDLE && start;
    assign busy    = state == SHIFT;
    always_comb begin
        state_nxt = accept ? SHIFT : (state == SHIFT && last) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) begin
                opa <= a;
                opb <= b;
                brw <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                res <= res_nxt;
                opa <= opa >> 1;
                opb <= opb >> 1;
                brw <= bo;
                cnt <= cnt + CW'(1);
                if (last) begin
                    diff <= res_nxt;
                    bout <= bo;
                    done <= 1'b1;
                end
            end
        end
    end
`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == SHIFT && last) begin
            ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor_nand.sv
// tb_serial_subtractor_nand: scoreboard bench for the 8-bit serial subtractor;
// expected results are hand-computed and popped by a monitor on every done pulse.
module tb_serial_subtractor_nand;
    localparam logic OVF =
`ifdef SERIAL_SUB_OVF_EN
        1'b1;
`else
        1'b0;
`endif
    localparam int GAP = 9;
    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, bout, ovf;
    logic [7:0] diff;
    exp_t sb[$];
    int checks = 0, failures = 0, done_cnt = 0;
    time t_prev;
    serial_subtractor_nand #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.bo);
                    chk("ovf", ovf, e.ov);
                end
            end
        end
    endtask
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed,
                          input logic eb, input logic ev);
        exp_t e;
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        e.d = ed; e.bo = eb; e.ov = ev;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk("busy_during_op", busy, 1);
            chk("no_early_done", done, 0);
            @(negedge clk);
        end
        chk("busy_after_op", busy, 0);
        chk("done_latency", done, 1);
    endtask
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        if (!done) chk(name, 0, 1);
    endtask
    initial begin
        exp_t e;
        int dc;
        logic [7:0] pa[4] = '{8'h10, 8'h64, 8'h01, 8'hC8};
        logic [7:0] pb[4] = '{8'h01, 8'h32, 8'h02, 8'h37};
        logic [7:0] pd[4] = '{8'h0F, 8'h32, 8'hFF, 8'h91};
        logic       pbo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none
        #15;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, OVF);
        run_op(8'h7F, 8'h80, 8'hFF, 1'b1, OVF);
        // start pulse mid-operation must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        e.d = 8'h0F; e.bo = 1'b0; e.ov = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = done_cnt;
        repeat (20) @(negedge clk);
        chk("single_done_cnt", done_cnt - dc, 1);
        chk("busy_idle_after_ignore", busy, 0);
        // back-to-back with start held high
        @(negedge clk);
        a = pa[0]; b = pb[0]; start = 1'b1;
        e.d = pd[0]; e.bo = pbo[0]; e.ov = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            wait_done("b2b_timeout");
            if (i > 0) chk("b2b_gap", 32'(($time - t_prev) / 10), GAP);
            t_prev = $time;
            if (i < 3) begin
                a = pa[i+1]; b = pb[i+1];
                e.d = pd[i+1]; e.bo = pbo[i+1]; e.ov = 1'b0;
                sb.push_back(e);
            end else begin
                start = 1'b0;
            end
        end
        repeat (12) @(negedge clk);
        chk("b2b_queue_empty", sb.size(), 0);
        // reset mid-operation discards the result
        @(negedge clk);
        a = 8'h20; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        chk("midrst_ovf", ovf, 0);
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);
        run_op(8'h09, 8'h09, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
